// File: rtl/raster_window_ctrl.sv
// Sequencer for a KxK sliding-window datapath: tracks raster position of the input stream,
// gates line-buffer writes, issues one window strobe per output pixel and aligns it to the filter result.
module raster_window_ctrl #(
    parameter int WIDTH  = 30,
    parameter int HEIGHT = 30,
    parameter int K      = 3,
    parameter int LAT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_i,
    output logic                       lb_we_o,
    output logic                       done_o,
    output logic [$clog2(HEIGHT)-1:0]  row_o,
    output logic [$clog2(WIDTH)-1:0]   col_o,
    output logic                       border_o,
    output logic                       frame_done_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam int R      = (K - 1) / 2;
    localparam int FILL_N = R * WIDTH + R;
    localparam int TOTAL  = WIDTH * HEIGHT;
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int FL_W   = $clog2(FILL_N + 1);
    localparam int PIPE_W = 3 + ROW_W + COL_W;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_N - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TOTAL - 1);
    localparam logic [FL_W-1:0]  FL_ONE    = FL_W'(1);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FILL_N - 1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LO    = ROW_W'(R);
    localparam logic [ROW_W-1:0] ROW_HI    = ROW_W'(HEIGHT - R);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LO    = COL_W'(R);
    localparam logic [COL_W-1:0] COL_HI    = COL_W'(WIDTH - R);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    in_cnt_reg;
    logic [FL_W-1:0]     fl_cnt_reg;
    logic [ROW_W-1:0]    cen_row_reg;
    logic [COL_W-1:0]    cen_col_reg;
    logic [PIPE_W-1:0]   s0_reg;
    logic                overrun_reg;

    logic accept;
    logic strobe;
    logic flush_end;
    logic border_c;

    assign accept    = done_i && (state_reg != ST_FLUSH);
    assign strobe    = (state_reg == ST_FLUSH) || ((state_reg == ST_RUN) && accept);
    assign flush_end = (state_reg == ST_FLUSH) && (fl_cnt_reg == FL_LAST);
    assign border_c  = (cen_row_reg < ROW_LO) || (cen_row_reg >= ROW_HI) ||
                       (cen_col_reg < COL_LO) || (cen_col_reg >= COL_HI);

    assign lb_we_o   = accept;
    assign busy_o    = (state_reg != ST_IDLE);
    assign overrun_o = overrun_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            in_cnt_reg  <= '0;
            fl_cnt_reg  <= '0;
            cen_row_reg <= '0;
            cen_col_reg <= '0;
            s0_reg      <= '0;
            overrun_reg <= 1'b0;
        end else begin
            // Stage 0 snapshots the centre before it advances, so the strobe carries its own position
            s0_reg <= {strobe, flush_end, strobe && border_c, cen_row_reg, cen_col_reg};

            if (strobe) begin
                if (cen_col_reg == COL_MAX) begin
                    cen_col_reg <= '0;
                    cen_row_reg <= cen_row_reg + ROW_ONE;
                end else begin
                    cen_col_reg <= cen_col_reg + COL_ONE;
                end
            end

            if (done_i && (state_reg == ST_FLUSH)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        in_cnt_reg <= CNT_ONE;
                        state_reg  <= (FILL_N == 1) ? ST_RUN : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        in_cnt_reg <= in_cnt_reg + CNT_ONE;
                        if (in_cnt_reg == FILL_LAST) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        in_cnt_reg <= in_cnt_reg + CNT_ONE;
                        if (in_cnt_reg == RUN_LAST) begin
                            state_reg  <= ST_FLUSH;
                            fl_cnt_reg <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    fl_cnt_reg <= fl_cnt_reg + FL_ONE;
                    if (flush_end) begin
                        // Centre clear overrides the wrap from the final strobe above
                        state_reg   <= ST_IDLE;
                        in_cnt_reg  <= '0;
                        fl_cnt_reg  <= '0;
                        cen_row_reg <= '0;
                        cen_col_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Alignment pipe; it drains independently of the FSM so a following frame never truncates it
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_pipe
            logic [PIPE_W-1:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= s0_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_pipe[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign {done_o, frame_done_o, border_o, row_o, col_o} = g_pipe[LAT-1].stage_reg;

endmodule

// File: tb/tb_raster_window_ctrl.sv
// Bench for raster_window_ctrl: directed frame scenarios with random gaps, checked cycle by cycle
// against a pixel-count model that schedules each expected output LAT cycles after its strobe.
module tb_raster_window_ctrl;

    localparam int W      = 30;
    localparam int H      = 30;
    localparam int K      = 3;
    localparam int LAT    = 2;
    localparam int R      = (K - 1) / 2;
    localparam int FILL_N = R * W + R;
    localparam int N      = W * H;

    logic                    clk;
    logic                    rst;
    logic                    done_i;
    logic                    lb_we_o;
    logic                    done_o;
    logic [$clog2(H)-1:0]    row_o;
    logic [$clog2(W)-1:0]    col_o;
    logic                    border_o;
    logic                    frame_done_o;
    logic                    busy_o;
    logic                    overrun_o;

    raster_window_ctrl #(.WIDTH(W), .HEIGHT(H), .K(K), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .done_i       (done_i),
        .lb_we_o      (lb_we_o),
        .done_o       (done_o),
        .row_o        (row_o),
        .col_o        (col_o),
        .border_o     (border_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int row;
        int col;
        bit border;
        bit last;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   m_cnt;
    int   m_flush_left;
    int   m_idx;
    bit   m_overrun;

    int   n_checks;
    int   n_pass;
    int   done_seen;
    int   border_seen;
    int   fdone_seen;
    int   first_done;
    int   last_done;
    int   frame_start;
    int   acc32;
    int   obs_border [H][W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt        = 0;
        m_flush_left = 0;
        m_idx        = 0;
        m_overrun    = 1'b0;
    endtask

    task automatic push_strobe(input bit last);
        exp_t e;
        e.due    = cyc + LAT;
        e.row    = m_idx / W;
        e.col    = m_idx % W;
        e.border = (e.row < R) || (e.row >= H - R) || (e.col < R) || (e.col >= W - R);
        e.last   = last;
        q.push_back(e);
        m_idx = last ? 0 : m_idx + 1;
    endtask

    // One clock edge of the reference: a frame is N accepted pixels, outputs begin after FILL_N of them,
    // and the remaining FILL_N centres are produced on consecutive cycles after the last pixel.
    task automatic model_edge(input bit d);
        if (m_flush_left > 0) begin
            if (d) m_overrun = 1'b1;
            m_flush_left--;
            push_strobe(m_flush_left == 0);
        end else if (d) begin
            m_cnt++;
            if (m_cnt > FILL_N) push_strobe(1'b0);
            if (m_cnt == N) begin
                m_cnt        = 0;
                m_flush_left = FILL_N;
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        bit   exp_done;
        exp_done = (q.size() > 0) && (q[0].due == cyc);
        chk("done_o", done_o, exp_done);
        if (exp_done) begin
            e = q.pop_front();
            chk("row_o", row_o, e.row);
            chk("col_o", col_o, e.col);
            chk("border_o", border_o, e.border);
            chk("frame_done_o", frame_done_o, e.last);
        end else begin
            chk("frame_done_idle", frame_done_o, 0);
        end
        chk("busy_o", busy_o, (m_cnt != 0) || (m_flush_left != 0));
        chk("overrun_o", overrun_o, m_overrun);
        if (done_o === 1'b1) begin
            done_seen++;
            if (border_o === 1'b1) border_seen++;
            if (frame_done_o === 1'b1) fdone_seen++;
            if (first_done < 0) first_done = cyc;
            last_done = cyc;
            if (row_o < H && col_o < W) obs_border[row_o][col_o] = int'(border_o);
        end
    endtask

    // Starts and ends on a falling edge
    task automatic step(input bit d);
        check_outputs();
        done_i = d;
        #1;
        chk("lb_we_o", lb_we_o, d && (m_flush_left == 0));
        @(posedge clk);
        cyc++;
        model_edge(d);
        @(negedge clk);
    endtask

    task automatic clear_stats();
        done_seen   = 0;
        border_seen = 0;
        fdone_seen  = 0;
        first_done  = -1;
        last_done   = -1;
        frame_start = -1;
        acc32       = -1;
    endtask

    // mode 0: continuous, 1: toggle, 2: random gaps, 3: hold off during flush only
    task automatic run_frame(input int mode, input int npix);
        int acc;
        bit tog;
        bit d;
        acc = 0;
        tog = 1'b1;
        while (acc < npix) begin
            case (mode)
                0:       d = 1'b1;
                1:       begin d = tog; tog = !tog; end
                2:       d = 1'($urandom_range(0, 1));
                default: d = (m_flush_left == 0);
            endcase
            if (d && m_flush_left == 0) begin
                acc++;
                if (acc == 1) frame_start = cyc + 1;
                if (acc == FILL_N + 1) acc32 = cyc + 1;
            end
            step(d);
        end
    endtask

    task automatic drain(input bit hold_high);
        int i;
        i = 0;
        while ((q.size() > 0 || m_flush_left > 0) && i < 300) begin
            step(hold_high && (m_flush_left > 0));
            i++;
        end
        chk("drain_bound", i < 300, 1);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        done_i = 1'b0;
        @(posedge clk);
        cyc++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        done_i   = 1'b0;
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_done_o", done_o, 0);
        chk("rst_row_o", row_o, 0);
        chk("rst_col_o", col_o, 0);
        chk("rst_border_o", border_o, 0);
        chk("rst_frame_done_o", frame_done_o, 0);
        chk("rst_busy_o", busy_o, 0);
        chk("rst_overrun_o", overrun_o, 0);
        repeat (3) step(1'b0);

        // Continuous frame, timing and border map
        clear_stats();
        run_frame(0, N);
        drain(1'b0);
        chk("t1_count", done_seen, N);
        chk("t1_frame_done", fdone_seen, 1);
        chk("t1_first_lat", first_done - frame_start, 33);
        chk("t1_last_lat", last_done - frame_start, 932);
        chk("t2_border_count", border_seen, 116);
        chk("t2_border_1_1", obs_border[1][1], 0);
        chk("t2_border_28_28", obs_border[28][28], 0);
        chk("t2_border_0_5", obs_border[0][5], 1);
        chk("t2_border_29_5", obs_border[29][5], 1);
        repeat (4) step(1'b0);

        // Alternating input
        clear_stats();
        run_frame(1, N);
        drain(1'b0);
        chk("t3_count", done_seen, N);
        chk("t3_first_after_32nd", first_done - acc32, LAT);
        chk("t3_frame_done", fdone_seen, 1);

        // Random gaps
        clear_stats();
        run_frame(2, N);
        drain(1'b0);
        chk("tr_count", done_seen, N);
        chk("tr_frame_done", fdone_seen, 1);

        // Reset in the middle of a frame, then a clean frame
        clear_stats();
        run_frame(0, 500);
        do_reset();
        chk("t4_done_after_rst", done_o, 0);
        chk("t4_busy_after_rst", busy_o, 0);
        repeat (2) step(1'b0);
        clear_stats();
        run_frame(0, N);
        drain(1'b0);
        chk("t4_count", done_seen, N);
        chk("t4_first_lat", first_done - frame_start, 33);
        chk("t4_last_lat", last_done - frame_start, 932);

        // Back-to-back frames
        clear_stats();
        run_frame(3, N);
        run_frame(3, N);
        drain(1'b0);
        chk("t5_count", done_seen, 2 * N);
        chk("t5_frame_done", fdone_seen, 2);
        chk("t5_no_overrun", overrun_o, 0);

        // Input held high through the flush
        clear_stats();
        run_frame(0, N);
        drain(1'b1);
        repeat (3) step(1'b0);
        chk("t6_overrun", overrun_o, 1);
        chk("t6_count", done_seen, N);
        chk("t6_frame_done", fdone_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
